mux_4to1: RTL and testbench



---
 rtl/mux_4to1_if.sv | 35 +++
 rtl/mux_4to1.sv | 91 +++++++++
 tb/tb_mux_4to1.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mux_4to1_if.sv
// ---------------------------------------------------------------------------
// mux_4to1_if
//   Groups the data/select/qualify bus of mux_4to1.
//   Signals:
//     a, b, c, d  [WIDTH]  sources 0..3
//     sel         [2]      source select, sel[1] is the MSB
//     en          [1]      load / qualify strobe
//     out         [WIDTH]  selected data
//     out_valid   [1]      out carries data qualified by en
//   Modports:
//     master - drives sources, select and strobe; observes the result
//     slave  - the mux itself
// ---------------------------------------------------------------------------
interface mux_4to1_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [1:0]       sel;
  logic             en;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  modport master (
    output a, b, c, d, sel, en,
    input  out, out_valid
  );

  modport slave (
    input  a, b, c, d, sel, en,
    output out, out_valid
  );
endinterface

// File: rtl/mux_4to1.sv
// ---------------------------------------------------------------------------
// mux_4to1
//   Four-input, one-output selector steering one of four equal-width sources
//   onto a single bus, with an optional output register.
//
//   Build option:
//     MUX_4_1_OUT_REG_EN  defined   -> out/out_valid registered on the rising
//                                      clk edge, loaded when en=1, cleared
//                                      asynchronously by rst_n=0.
//                         undefined -> pure combinational mux, out_valid=en,
//                                      clk and rst_n unused.
//
//   Ports:
//     clk    input   rising-edge clock (registered build only)
//     rst_n  input   asynchronous active-low reset (registered build only)
//     bus    slave   mux_4to1_if: a, b, c, d, sel, en in; out, out_valid out
//
//   Parameters:
//     WIDTH  bit width of each source and of out (must match the interface)
// ---------------------------------------------------------------------------
module mux_4to1 #(
  parameter int WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_4to1_if.slave   bus
);

  logic [WIDTH-1:0] mux_s;

  // Source selection; an unknown select yields all-X in simulation so a bad
  // select is visible downstream instead of silently picking a source.
  always_comb begin
    mux_s = {WIDTH{1'b0}};
    case (bus.sel)
      2'd0:    mux_s = bus.a;
      2'd1:    mux_s = bus.b;
      2'd2:    mux_s = bus.c;
      2'd3:    mux_s = bus.d;
      default: mux_s = {WIDTH{1'bx}};
    endcase
  end

`ifdef MUX_4_1_OUT_REG_EN

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             valid_d;
  logic             valid_q;

  // Next-state: load the selected source on en, otherwise hold the data and
  // drop the valid flag for this cycle.
  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    if (bus.en) begin
      out_d   = mux_s;
      valid_d = 1'b1;
    end else begin
      out_d   = out_q;
      valid_d = 1'b0;
    end
  end

  // Output register; reset clears data and valid without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;

`else

  // clk and rst_n are kept on the port list so both builds share one
  // footprint; they have no function in the combinational build.
  logic unused_clk_rst_s;
  assign unused_clk_rst_s = clk ^ rst_n;

  assign bus.out       = mux_s;
  assign bus.out_valid = bus.en;

`endif

endmodule

// File: tb/tb_mux_4to1.sv
// ---------------------------------------------------------------------------
// tb_mux_4to1
//   Self-checking bench for mux_4to1 (WIDTH=8). Exercises the combinational
//   build by default and the registered build when MUX_4_1_OUT_REG_EN is
//   defined. Expected values come from an array-indexed reference model.
// ---------------------------------------------------------------------------
module tb_mux_4to1;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  mux_4to1_if #(.WIDTH(W)) bus_if ();

  mux_4to1 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: index an array of the four sources by the select value.
  function automatic logic [W-1:0] ref_mux(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] c,
                                           input logic [W-1:0] d,
                                           input logic [1:0]   sel);
    logic [W-1:0] src [4];
    src[0] = a;
    src[1] = b;
    src[2] = c;
    src[3] = d;
    return src[int'(sel)];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d,
                       input logic [1:0] sel, input logic en);
    bus_if.a   = a;
    bus_if.b   = b;
    bus_if.c   = c;
    bus_if.d   = d;
    bus_if.sel = sel;
    bus_if.en  = en;
  endtask

`ifdef MUX_4_1_OUT_REG_EN
  logic [W-1:0] exp_out;
  logic         exp_v;

  // One clock: update the model from the inputs seen at the rising edge,
  // then compare on the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst_n) begin
      exp_out = '0;
      exp_v   = 1'b0;
    end else if (bus_if.en) begin
      exp_out = ref_mux(bus_if.a, bus_if.b, bus_if.c, bus_if.d, bus_if.sel);
      exp_v   = 1'b1;
    end else begin
      exp_v   = 1'b0;
    end
    @(negedge clk);
    check({tag, "_out"}, bus_if.out, exp_out);
    check({tag, "_valid"}, {{(W-1){1'b0}}, bus_if.out_valid}, {{(W-1){1'b0}}, exp_v});
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);

`ifdef MUX_4_1_OUT_REG_EN
    exp_out = '0;
    exp_v   = 1'b0;
    #12;
    check("rst_out", bus_if.out, 8'h00);
    check("rst_valid", {7'd0, bus_if.out_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick("idle");

    // Single-cycle load, then hold with en=0.
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'd3, 1'b1);
    tick("lat");
    check("lat_const", bus_if.out, 8'h44);
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'd3, 1'b0);
    tick("lat_hold");
    check("lat_hold_const", bus_if.out, 8'h44);

    // Asynchronous reset in the middle of the low phase.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", bus_if.out, 8'h00);
    check("arst_valid", {7'd0, bus_if.out_valid}, 8'h00);
    exp_out = '0;
    exp_v   = 1'b0;
    tick("arst_held");
    rst_n = 1'b1;
    tick("arst_rel");

    // Reload, then scramble select and data with en=0.
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'd3, 1'b1);
    tick("reload");
    for (int s = 0; s < 3; s++) begin
      drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'(s), 1'b0);
      tick("hold");
      check("hold_const", bus_if.out, 8'h44);
    end

    // Back-to-back loads.
    for (int s = 0; s < 4; s++) begin
      drive(8'h11, 8'h22, 8'h33, 8'h44, 2'(s), 1'b1);
      tick("b2b");
      check("b2b_const", bus_if.out, 8'((s + 1) * 8'h11));
    end

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
      tick("rnd");
    end
`else
    #3;
    check("idle_valid", {7'd0, bus_if.out_valid}, 8'h00);
    check("idle_out", bus_if.out, 8'h00);

    // Directed cases: sources must never be swapped.
    drive(8'h00, 8'h00, 8'h00, 8'hFF, 2'd1, 1'b1);
    #5;
    check("noswap", bus_if.out, 8'h00);
    check("noswap_valid", {7'd0, bus_if.out_valid}, 8'h01);
    drive(8'h00, 8'hFF, 8'hFF, 8'h00, 2'd2, 1'b0);
    #5;
    check("p0110_s2", bus_if.out, 8'hFF);
    drive(8'hFF, 8'hFF, 8'h00, 8'hFF, 2'd1, 1'b1);
    #5;
    check("p1101_s1", bus_if.out, 8'hFF);

    // Exhaustive bit patterns {a,b,c,d} x every select, en ignored by data.
    for (int p = 0; p < 16; p++) begin
      for (int s = 0; s < 4; s++) begin
        logic [3:0] pat;
        logic       e;
        pat = 4'(p);
        e   = 1'($urandom_range(1, 0));
        drive({W{pat[3]}}, {W{pat[2]}}, {W{pat[1]}}, {W{pat[0]}}, 2'(s), e);
        #5;
        check("exh_out", bus_if.out,
              ref_mux({W{pat[3]}}, {W{pat[2]}}, {W{pat[1]}}, {W{pat[0]}}, 2'(s)));
        check("exh_valid", {7'd0, bus_if.out_valid}, {7'd0, e});
      end
    end

    // Random wide data.
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb, rc, rd;
      logic [1:0]   rs;
      logic         re;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 8'($urandom);
      rd = 8'($urandom);
      rs = 2'($urandom_range(3, 0));
      re = 1'($urandom_range(1, 0));
      drive(ra, rb, rc, rd, rs, re);
      #5;
      check("rnd_out", bus_if.out, ref_mux(ra, rb, rc, rd, rs));
      check("rnd_valid", {7'd0, bus_if.out_valid}, {7'd0, re});
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
